// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch-queue entry layout and fetch FSM state encoding.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } ifq_state_t;

    localparam logic [31:0] IFQ_PC_STEP = 32'd4;

    // Redirect targets are word aligned; the low two bits are ignored.
    function automatic logic [31:0] ifq_align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the fetch queue's memory-port, redirect and decode-side handshake signals.
interface instr_fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          instr_read;
    logic [31:0]   instr_mem_address;
    logic          instr_mem_resp;
    logic [31:0]   instr_mem_rdata;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          deq_ready;
    logic          deq_valid;
    logic [31:0]   deq_instr;
    logic [31:0]   deq_pc;
    logic [CW-1:0] count;

    // The fetch queue masters the instruction-memory read and sources the decode entry.
    modport master (
        output instr_read, instr_mem_address, deq_valid, deq_instr, deq_pc, count,
        input  instr_mem_resp, instr_mem_rdata, flush, flush_pc, deq_ready
    );

    modport slave (
        input  instr_read, instr_mem_address, deq_valid, deq_instr, deq_pc, count,
        output instr_mem_resp, instr_mem_rdata, flush, flush_pc, deq_ready
    );

endinterface

// File: rtl/ifq_ring.sv
// DEPTH-entry circular buffer of fetch entries with push, pop, synchronous clear and occupancy.
module ifq_ring
    import rv32i_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  ifq_entry_t             i_entry,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output ifq_entry_t             o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifq_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop = i_pop && (r_count != '0);

    // Pointers are AW bits wide, so the increment wraps modulo DEPTH by itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_tail] <= i_entry;
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues sequential instruction reads and queues {pc, instr} for decode.
// Optional statistics counters are built when IFQ_STAT_EN is defined.
module instr_fetch_queue
    import rv32i_types::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
`ifdef IFQ_STAT_EN
    ,
    output logic [31:0]         stat_fetched,
    output logic [31:0]         stat_full_cycles
`endif
);
    localparam int          CW   = $clog2(DEPTH) + 1;
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    ifq_state_t    r_state;
    ifq_state_t    w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   r_drop_addr;
    logic [31:0]   w_drop_addr_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_clear;
    ifq_entry_t    w_entry;
    ifq_entry_t    w_head;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_count_ext;
    logic [CW:0]   w_count_post;

    ifq_ring #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // A flush wins over a dequeue in the same cycle.
    assign w_clear      = bus.flush;
    assign w_pop        = bus.deq_ready && (w_count != '0) && !bus.flush;
    assign w_entry      = '{pc: r_pc, instr: bus.instr_mem_rdata};
    assign w_count_ext  = {1'b0, w_count};
    assign w_count_post = w_count_ext + (CW + 1)'(w_push) - (CW + 1)'(w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop_addr <= w_drop_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_addr_nxt = r_drop_addr;
        w_push          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.flush) begin
                    w_pc_nxt    = ifq_align_pc(bus.flush_pc);
                    w_state_nxt = REQ;
                end else if (w_count_ext < FULL) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.flush) begin
                    w_pc_nxt = ifq_align_pc(bus.flush_pc);
                    // Memory cannot abort a read: keep the old address up until it answers.
                    if (bus.instr_mem_resp) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt     = DROP;
                        w_drop_addr_nxt = r_pc;
                    end
                end else if (bus.instr_mem_resp) begin
                    w_push      = 1'b1;
                    w_pc_nxt    = r_pc + IFQ_PC_STEP;
                    w_state_nxt = (w_count_post < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.flush) w_pc_nxt = ifq_align_pc(bus.flush_pc);
                if (bus.instr_mem_resp) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.instr_read        = (r_state != IDLE);
    assign bus.instr_mem_address = (r_state == DROP) ? r_drop_addr : r_pc;
    assign bus.deq_valid         = (w_count != '0);
    assign bus.deq_instr         = w_head.instr;
    assign bus.deq_pc            = w_head.pc;
    assign bus.count             = w_count;

`ifdef IFQ_STAT_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_full_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_fetched     <= '0;
            r_stat_full_cycles <= '0;
        end else begin
            if (w_push)               r_stat_fetched     <= r_stat_fetched + 32'd1;
            if (w_count_ext == FULL)  r_stat_full_cycles <= r_stat_full_cycles + 32'd1;
        end
    end

    assign stat_fetched     = r_stat_fetched;
    assign stat_full_cycles = r_stat_full_cycles;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: fill, stall, flush/drop, streaming wrap and mid-run reset.
module tb_instr_fetch_queue;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    instr_fetch_queue_if #(.DEPTH(8)) bus ();

`ifdef IFQ_STAT_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_full_cycles;
`endif

    instr_fetch_queue #(.DEPTH(8), .RESET_PC(32'h0000_0060)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFQ_STAT_EN
        ,
        .stat_fetched     (stat_fetched),
        .stat_full_cycles (stat_full_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return 32'hC000_0000 ^ addr;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.instr_mem_resp  = 1'b0;
        bus.instr_mem_rdata = 32'h0;
        bus.flush           = 1'b0;
        bus.flush_pc        = 32'h0;
        bus.deq_ready       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read",  {63'd0, bus.instr_read}, 64'd0);
        chk("rst_addr",  {32'd0, bus.instr_mem_address}, 64'h60);
        chk("rst_valid", {63'd0, bus.deq_valid}, 64'd0);
        chk("rst_count", {60'd0, bus.count}, 64'd0);
        rst = 1'b1;
        step();
        chk("first_read", {63'd0, bus.instr_read}, 64'd1);
        chk("first_addr", {32'd0, bus.instr_mem_address}, 64'h60);

        // Fill with single-cycle responses while decode stalls
        for (int i = 0; i < 8; i++) begin
            chk("fill_addr", {32'd0, bus.instr_mem_address}, 64'(32'h60 + 32'(4 * i)));
            bus.instr_mem_resp  = 1'b1;
            bus.instr_mem_rdata = word_of(32'h60 + 32'(4 * i));
            step();
            if (i == 0) begin
                chk("lat_valid", {63'd0, bus.deq_valid}, 64'd1);
                chk("lat_pc",    {32'd0, bus.deq_pc}, 64'h60);
                chk("lat_instr", {32'd0, bus.deq_instr}, 64'(word_of(32'h60)));
            end
        end
        bus.instr_mem_resp = 1'b0;
        chk("full_count", {60'd0, bus.count}, 64'd8);
        chk("full_read",  {63'd0, bus.instr_read}, 64'd0);
        step();
        chk("full_hold_read", {63'd0, bus.instr_read}, 64'd0);
        bus.deq_ready = 1'b1;
        step();
        bus.deq_ready = 1'b0;
        chk("pop_count", {60'd0, bus.count}, 64'd7);
        chk("pop_pc",    {32'd0, bus.deq_pc}, 64'h64);
        chk("pop_read",  {63'd0, bus.instr_read}, 64'd0);
        step();
        chk("refetch_read", {63'd0, bus.instr_read}, 64'd1);
        chk("refetch_addr", {32'd0, bus.instr_mem_address}, 64'h80);

        // Flush with a request outstanding: old address held, its response dropped
        bus.flush     = 1'b1;
        bus.flush_pc  = 32'h203;
        bus.deq_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.deq_ready = 1'b0;
        chk("drop_count", {60'd0, bus.count}, 64'd0);
        chk("drop_valid", {63'd0, bus.deq_valid}, 64'd0);
        chk("drop_read",  {63'd0, bus.instr_read}, 64'd1);
        chk("drop_addr",  {32'd0, bus.instr_mem_address}, 64'h80);
        step();
        step();
        chk("drop_addr_hold", {32'd0, bus.instr_mem_address}, 64'h80);
        bus.instr_mem_resp  = 1'b1;
        bus.instr_mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.instr_mem_resp = 1'b0;
        chk("dropped_count", {60'd0, bus.count}, 64'd0);
        chk("redir_read",    {63'd0, bus.instr_read}, 64'd1);
        chk("redir_addr",    {32'd0, bus.instr_mem_address}, 64'h200);
        bus.instr_mem_resp  = 1'b1;
        bus.instr_mem_rdata = word_of(32'h200);
        step();
        bus.instr_mem_resp = 1'b0;
        chk("redir_count", {60'd0, bus.count}, 64'd1);
        chk("redir_pc",    {32'd0, bus.deq_pc}, 64'h200);
        chk("redir_next",  {32'd0, bus.instr_mem_address}, 64'h204);

        // Flush coinciding with a response: word discarded, fetch restarts at flush_pc
        bus.flush           = 1'b1;
        bus.flush_pc        = 32'h400;
        bus.instr_mem_resp  = 1'b1;
        bus.instr_mem_rdata = word_of(32'h204);
        step();
        bus.flush          = 1'b0;
        bus.instr_mem_resp = 1'b0;
        chk("fr_count", {60'd0, bus.count}, 64'd0);
        chk("fr_valid", {63'd0, bus.deq_valid}, 64'd0);
        chk("fr_read",  {63'd0, bus.instr_read}, 64'd1);
        chk("fr_addr",  {32'd0, bus.instr_mem_address}, 64'h400);

        // Stream at count 5 with enqueue and dequeue every cycle across pointer wrap
        for (int i = 0; i < 5; i++) begin
            bus.instr_mem_resp  = 1'b1;
            bus.instr_mem_rdata = word_of(32'h400 + 32'(4 * i));
            step();
        end
        chk("s_count0", {60'd0, bus.count}, 64'd5);
        chk("s_pc0",    {32'd0, bus.deq_pc}, 64'h400);
        bus.deq_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            bus.instr_mem_rdata = word_of(32'h414 + 32'(4 * (k - 1)));
            step();
            chk("s_count", {60'd0, bus.count}, 64'd5);
            chk("s_pc",    {32'd0, bus.deq_pc}, 64'(32'h400 + 32'(4 * k)));
            chk("s_instr", {32'd0, bus.deq_instr}, 64'(word_of(32'h400 + 32'(4 * k))));
        end
        bus.instr_mem_resp = 1'b0;
        bus.deq_ready      = 1'b0;
        chk("s_addr", {32'd0, bus.instr_mem_address}, 64'h464);
`ifdef IFQ_STAT_EN
        chk("stat_fetched", {32'd0, stat_fetched}, 64'd34);
        chk("stat_full",    {32'd0, stat_full_cycles}, 64'd2);
`endif

        // Asynchronous reset mid-request
        rst = 1'b0;
        #1;
        chk("arst_read",  {63'd0, bus.instr_read}, 64'd0);
        chk("arst_addr",  {32'd0, bus.instr_mem_address}, 64'h60);
        chk("arst_count", {60'd0, bus.count}, 64'd0);
        chk("arst_valid", {63'd0, bus.deq_valid}, 64'd0);
`ifdef IFQ_STAT_EN
        chk("arst_stat_fetched", {32'd0, stat_fetched}, 64'd0);
        chk("arst_stat_full",    {32'd0, stat_full_cycles}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk("rel_read", {63'd0, bus.instr_read}, 64'd1);
        chk("rel_addr", {32'd0, bus.instr_mem_address}, 64'h60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
